// File: rtl/ps2_event_queue.sv
// ps2_event_queue
//   Turns the raw PS/2 scan-code byte stream into decoded key events
//   (make/break, E0 extended prefix, E1 Pause sequence). Events go into a
//   show-ahead FIFO that the CPU polls through a memory-mapped read path.
//
//   Event word: {valid, 5'b0, ext, rel, code[7:0]}; 16'h0000 when empty.
//
//   Handshake: rx_valid is a one-cycle strobe qualifying rx_byte, with no
//   back-pressure; one byte is consumed per strobe. ren pops the head entry
//   at the clock edge only when count > 0, and is ignored while empty.
//
//   Optional feature: define PS2_REPEAT_FILTER_EN to suppress typematic
//   repeats. A make that matches the held key is not pushed.
//
//   dbg_state exposes the sequencer state so that checkers can be bound
//   to it.
module ps2_event_queue #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    input  logic                     ren,
    input  logic                     clr_ovf,
    output logic [15:0]              data,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [2:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_PAUSE   = 3'd4
    } state_t;

    state_t          state, next_state;
    logic [2:0]      pause_cnt, next_pause;
    logic [TW-1:0]   tmo_cnt;
    logic            timed_out;

    // Decoded event offered to the queue this cycle
    logic            ev_valid;
    logic            ev_ext;
    logic            ev_rel;
    logic [7:0]      ev_code;
    logic            push_req;

    // FIFO storage and bookkeeping
    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full, empty;
    logic            do_push, do_pop, drop;

    // Bytes the keyboard sends that are not key events (ACK, BAT, echo, resend, errors)
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    assign timed_out = (state != S_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Sequencer state, pause byte counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pause_cnt <= 3'd0;
        end else begin
            state     <= next_state;
            pause_cnt <= next_pause;
        end
    end

    // Inactivity timer: counts only inside a partial sequence, restarts on every byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (rx_valid || (state == S_IDLE) || timed_out) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Next-state decode and event generation
    always_comb begin
        next_state = state;
        next_pause = pause_cnt;
        ev_valid   = 1'b0;
        ev_ext     = 1'b0;
        ev_rel     = 1'b0;
        ev_code    = rx_byte;
        if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (rx_byte == 8'hE0) begin
                        next_state = S_EXT;
                    end else if (rx_byte == 8'hF0) begin
                        next_state = S_BRK;
                    end else if (rx_byte == 8'hE1) begin
                        next_state = S_PAUSE;
                        next_pause = 3'd7;
                    end else if (!is_ignored(rx_byte)) begin
                        ev_valid = 1'b1;
                    end
                end
                S_EXT: begin
                    if (rx_byte == 8'hF0) begin
                        next_state = S_EXT_BRK;
                    end else if (rx_byte != 8'hE0) begin
                        ev_valid   = 1'b1;
                        ev_ext     = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                S_BRK: begin
                    // A second prefix after F0 is a protocol error: drop it all
                    if ((rx_byte != 8'hE0) && (rx_byte != 8'hF0)) begin
                        ev_valid = 1'b1;
                        ev_rel   = 1'b1;
                    end
                    next_state = S_IDLE;
                end
                S_EXT_BRK: begin
                    if ((rx_byte != 8'hE0) && (rx_byte != 8'hF0)) begin
                        ev_valid = 1'b1;
                        ev_ext   = 1'b1;
                        ev_rel   = 1'b1;
                    end
                    next_state = S_IDLE;
                end
                S_PAUSE: begin
                    // Pause has no break code; the 8-byte burst maps to one event
                    if (pause_cnt <= 3'd1) begin
                        ev_valid   = 1'b1;
                        ev_ext     = 1'b1;
                        ev_code    = 8'hE1;
                        next_pause = 3'd0;
                        next_state = S_IDLE;
                    end else begin
                        next_pause = pause_cnt - 3'd1;
                    end
                end
                default: begin
                    next_state = S_IDLE;
                    next_pause = 3'd0;
                end
            endcase
        end else if (timed_out) begin
            next_state = S_IDLE;
            next_pause = 3'd0;
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic            held_valid;
    logic            held_ext;
    logic [7:0]      held_code;
    logic            held_match;

    assign held_match = held_valid && (held_ext == ev_ext) && (held_code == ev_code);
    assign push_req   = ev_valid && !(!ev_rel && held_match);

    // Track the key currently held down so typematic repeats can be filtered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid <= 1'b0;
            held_ext   <= 1'b0;
            held_code  <= 8'h00;
        end else if (ev_valid) begin
            if (!ev_rel) begin
                if (!held_match) begin
                    held_valid <= 1'b1;
                    held_ext   <= ev_ext;
                    held_code  <= ev_code;
                end
            end else if (held_match) begin
                held_valid <= 1'b0;
            end
        end
    end
`else
    assign push_req = ev_valid;
`endif

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = ren && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign do_push = push_req && (!full || do_pop);
    assign drop    = push_req && full && !do_pop;

    // Entry storage; no reset needed, validity is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {ev_ext, ev_rel, ev_code};
        end
    end

    // Pointers (wrap naturally, DEPTH is a power of two) and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a new drop wins over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Show-ahead read port
    always_comb begin
        data  = 16'h0000;
        ready = !empty;
        if (!empty) begin
            data = {1'b1, 5'b00000, mem[rd_ptr]};
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_ps2_event_queue.sv
// tb_ps2_event_queue
//   Directed tests for ps2_event_queue with hand-computed expected events.
module tb_ps2_event_queue;

    localparam int DEPTH = 16;
    localparam int TMO   = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        ren = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [15:0] data;
    logic        ready;
    logic [4:0]  count;
    logic        overflow;
    logic [2:0]  dbg_state;

    int vectors = 0;
    int errors  = 0;

    ps2_event_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .ren       (ren),
        .clr_ovf   (clr_ovf),
        .data      (data),
        .ready     (ready),
        .count     (count),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Driver tasks: inputs change on the falling edge, outputs read on the falling edge
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pop(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        ren      = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        ren      = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        #1;
        vectors++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        vectors++; if (data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=0000", data); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        vectors++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_make_break();
        send(8'h1C);
        vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL mb_ready_latency got=%b exp=1", ready); end
        vectors++; if (data !== 16'h801C) begin errors++; $display("FAIL mb_first got=%h exp=801c", data); end
        send(8'hF0);
        send(8'h1C);
        vectors++; if (count !== 5'd2) begin errors++; $display("FAIL mb_count got=%0d exp=2", count); end
        pop();
        vectors++; if (data !== 16'h811C) begin errors++; $display("FAIL mb_break got=%h exp=811c", data); end
        pop();
        vectors++; if (data !== 16'h0000) begin errors++; $display("FAIL mb_empty_data got=%h exp=0000", data); end
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL mb_empty_ready got=%b exp=0", ready); end
    endtask

    task automatic test_extended();
        send(8'hE0);
        send(8'h75);
        vectors++; if (count !== 5'd1) begin errors++; $display("FAIL ext_count1 got=%0d exp=1", count); end
        vectors++; if (data !== 16'h8275) begin errors++; $display("FAIL ext_make got=%h exp=8275", data); end
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        vectors++; if (count !== 5'd2) begin errors++; $display("FAIL ext_count2 got=%0d exp=2", count); end
        pop();
        vectors++; if (count !== 5'd1) begin errors++; $display("FAIL ext_count3 got=%0d exp=1", count); end
        vectors++; if (data !== 16'h8375) begin errors++; $display("FAIL ext_break got=%h exp=8375", data); end
        pop();
        vectors++; if (count !== 5'd0) begin errors++; $display("FAIL ext_count4 got=%0d exp=0", count); end
    endtask

    task automatic test_pause_ignore();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) begin
            send(seq[i]);
            if (i == 6) begin
                vectors++; if (count !== 5'd0) begin errors++; $display("FAIL pause_early got=%0d exp=0", count); end
            end
        end
        vectors++; if (count !== 5'd1) begin errors++; $display("FAIL pause_count got=%0d exp=1", count); end
        vectors++; if (data !== 16'h82E1) begin errors++; $display("FAIL pause_data got=%h exp=82e1", data); end
        pop();
        send(8'hFA);
        send(8'hAA);
        send(8'hFE);
        vectors++; if (count !== 5'd0) begin errors++; $display("FAIL ignore_count got=%0d exp=0", count); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_q [$];
        for (int i = 1; i <= DEPTH + 1; i++) send(8'(i));
        vectors++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
        vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        vectors++; if (data !== 16'h8001) begin errors++; $display("FAIL ovf_head got=%h exp=8001", data); end
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        send_pop(8'h12);
        vectors++; if (count !== 5'd16) begin errors++; $display("FAIL full_pushpop_count got=%0d exp=16", count); end
        vectors++; if (data !== 16'h8002) begin errors++; $display("FAIL full_pushpop_head got=%h exp=8002", data); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf got=%b exp=0", overflow); end
        // Clear and drop in the same cycle: the drop must win
        @(negedge clk);
        rx_byte = 8'h13; rx_valid = 1'b1; clr_ovf = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; clr_ovf = 1'b0;
        vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        for (int i = 2; i <= 16; i++) exp_q.push_back(16'h8000 | 16'(i));
        exp_q.push_back(16'h8012);
        while (exp_q.size() > 0) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            vectors++; if (data !== e) begin errors++; $display("FAIL drain got=%h exp=%h", data, e); end
            pop();
        end
        vectors++; if (count !== 5'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
        pop();
        vectors++; if (count !== 5'd0) begin errors++; $display("FAIL underflow_count got=%0d exp=0", count); end
        send_pop(8'h21);
        vectors++; if (count !== 5'd1) begin errors++; $display("FAIL empty_pushpop_count got=%0d exp=1", count); end
        vectors++; if (data !== 16'h8021) begin errors++; $display("FAIL empty_pushpop_data got=%h exp=8021", data); end
        pop();
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
    endtask

    task automatic test_timeout();
        send(8'hF0);
        idle(TMO);
        send(8'h1C);
        vectors++; if (data !== 16'h801C) begin errors++; $display("FAIL timeout_make got=%h exp=801c", data); end
        pop();
        send(8'hF0);
        idle(TMO / 2);
        send(8'h1C);
        vectors++; if (data !== 16'h811C) begin errors++; $display("FAIL no_timeout_break got=%h exp=811c", data); end
        pop();
        send(8'h32);
        send(8'hE0);
        vectors++; if (dbg_state !== 3'd1) begin errors++; $display("FAIL ext_state got=%0d exp=1", dbg_state); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (count !== 5'd0) begin errors++; $display("FAIL midreset_count got=%0d exp=0", count); end
        vectors++; if (data !== 16'h0000) begin errors++; $display("FAIL midreset_data got=%h exp=0000", data); end
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h75);
        vectors++; if (data !== 16'h8075) begin errors++; $display("FAIL after_reset got=%h exp=8075", data); end
        pop();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rx_byte = 8'h1C; rx_valid = 1'b1;
        @(negedge clk);
        rx_byte = 8'h32;
        @(negedge clk);
        rx_byte = 8'hE0;
        @(negedge clk);
        rx_byte = 8'h74;
        @(negedge clk);
        rx_valid = 1'b0;
        vectors++; if (count !== 5'd3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", count); end
        vectors++; if (data !== 16'h801C) begin errors++; $display("FAIL b2b_first got=%h exp=801c", data); end
        pop();
        vectors++; if (data !== 16'h8032) begin errors++; $display("FAIL b2b_second got=%h exp=8032", data); end
        pop();
        vectors++; if (data !== 16'h8274) begin errors++; $display("FAIL b2b_third got=%h exp=8274", data); end
        pop();
    endtask

    task automatic test_repeat();
        logic [15:0] exp_q [$];
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
`ifdef PS2_REPEAT_FILTER_EN
        exp_q = '{16'h801C, 16'h811C};
`else
        exp_q = '{16'h801C, 16'h801C, 16'h801C, 16'h811C};
`endif
        vectors++; if (count !== 5'(exp_q.size())) begin errors++; $display("FAIL repeat_count got=%0d exp=%0d", count, exp_q.size()); end
        while (exp_q.size() > 0) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            vectors++; if (data !== e) begin errors++; $display("FAIL repeat_entry got=%h exp=%h", data, e); end
            pop();
        end
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL repeat_empty got=%b exp=0", ready); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_pause_ignore();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ps2_event_queue.md
Name: ps2_event_queue

Overview:
- Sequences the raw PS/2 receive byte stream into decoded key events: make/break, extended prefix, Pause sequence.
- Buffers events in a FIFO for CPU polling.
- Sits between the PS/2 byte receiver (byte + 1-cycle valid pulse) and the memory-mapped keyboard register read path.
- Replaces the "latest key only" register with a lossless, flagged event queue.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2.
TIMEOUT_CYCLES, 1000000, clk cycles without a byte before a partial prefix sequence is abandoned.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_byte  in  8  byte from PS/2 receiver
rx_valid  in  1  one-cycle strobe; rx_byte valid this cycle
ren  in  1  CPU read strobe; pops head entry
clr_ovf  in  1  clears overflow flag
data  out  16  head event: {valid, 5'b0, ext, rel, code[7:0]}; 16'h0000 when empty
ready  out  1  FIFO non-empty
count  out  $clog2(DEPTH)+1  entries held
overflow  out  1  sticky; an event was dropped

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, count=0, ready=0, data=0, overflow=0, timeout counter=0, pause counter=0.
- FIFO is show-ahead: data/ready are combinational from the head entry and count.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions occur only on rx_valid.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE with pause_cnt=7.
    - FA, AA, EE, FE, 00, FF -> ignored, stay IDLE.
    - Any other byte -> push {ext=0,rel=0,code}.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay EXT.
    - Other -> push {1,0,code}, go IDLE.
  - BRK:
    - E0 or F0 -> protocol error; drop sequence, go IDLE.
    - Other -> push {0,1,code}, go IDLE.
  - EXT_BRK:
    - E0 or F0 -> protocol error; drop, go IDLE.
    - Other -> push {1,1,code}, go IDLE.
  - PAUSE:
    - Each byte decrements pause_cnt; contents are not checked.
    - On the 7th byte, push {1,0,8'hE1} and go IDLE.
- Push latency: the event is in the FIFO the cycle after the rx_valid edge; ready is high that cycle.
- Timeout:
  - The counter runs while state != IDLE and clears on every rx_valid.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE and discards the partial sequence; no push.
  - The counter is held at 0 in IDLE.
- Pop: ren while count>0 advances the head at the clock edge. ren while empty is a no-op; no underflow and pointers are unchanged.
- Push when full:
  - With pop in the same cycle: both occur and count is unchanged.
  - Without pop: the event is dropped and overflow<=1.
- Push and pop in the same cycle while empty: push only; the new entry is visible the next cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- overflow: clr_ovf clears it. A simultaneous clr_ovf and new drop leaves it set (set wins).
- Only one push per cycle is possible; rx_valid pulses are at least 2 cycles apart by receiver design. Back-to-back pulses must still be handled, one byte per cycle.

Optional Feature:
Macro PS2_REPEAT_FILTER_EN.
- Defined:
  - Keep a held-key register: {held_valid, ext, code}.
  - A make event identical to the held key is suppressed (typematic repeat); no push.
  - Any other make pushes and replaces the held key.
  - A break matching the held key pushes and clears held_valid.
  - Other breaks push normally.
  - Reset clears held_valid.
- Undefined: every make (including typematic repeats) is pushed; no held-key logic is synthesized.

Test Plan:
1. Reset then bytes 1C, F0 1C -> two entries; reads give data=16'h801C then 16'h811C, then 16'h0000 with ready=0.
2. Bytes E0 75, E0 F0 75 -> data 16'h8275 then 16'h8375; count 1->2 then decrements on each ren.
3. Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one entry 16'h82E1; FA and AA in IDLE -> no entries.
4. Push DEPTH+1 makes (codes 01..11h) without ren -> count=16, overflow=1, head=16'h8001; clr_ovf -> overflow=0. A push+ren in the same cycle while full keeps count=16.
5. Byte F0, idle TIMEOUT_CYCLES cycles, then 1C -> entry 16'h801C (make, not break). rst_n low mid-sequence (after E0) -> FIFO empty; next byte 75 -> 16'h8075.
6. PS2_REPEAT_FILTER_EN defined: 1C 1C 1C F0 1C -> entries 16'h801C, 16'h811C only. Undefined -> four entries.
